minmax_window_tracker: RTL and testbench

//  Downstream consumer of the 4-bit magnitude comparator (magComp_gate).

---
 rtl/minmax_window_tracker_pkg.sv | 12 +
 rtl/minmax_window_tracker_if.sv | 29 ++
 rtl/minmax_window_tracker_magcomp.sv | 28 ++
 rtl/minmax_window_tracker.sv | 81 ++++++++
 tb/tb_minmax_window_tracker.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/minmax_window_tracker_pkg.sv
// Shared encodings and widths for the min/max window tracker and its comparators.
package minmax_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/minmax_window_tracker_if.sv
// Sample-in / result-out handshake bundle between a producer and the window tracker.
interface minmax_window_tracker_if
  import minmax_pkg::*;
#(
  parameter int CNT_W = 4
) ();

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] thresh;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] min_val;
  logic [DATA_W-1:0] max_val;
  logic [CNT_W-1:0]  gt_count;

  modport master (
    output start, in_valid, in_data, thresh, out_ready,
    input  in_ready, out_valid, min_val, max_val, gt_count
  );

  modport slave (
    input  start, in_valid, in_data, thresh, out_ready,
    output in_ready, out_valid, min_val, max_val, gt_count
  );

endinterface

// File: rtl/minmax_window_tracker_magcomp.sv
// Gate-level 4-bit unsigned magnitude comparator; decisions ripple from the MSB down.
module magComp_gate
  import minmax_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              agtb,
  output logic              aeqb,
  output logic              altb
);

  logic [3:0] e;

  assign e = ~(a ^ b);

  assign agtb = (a[3] & ~b[3])
              | (e[3] & a[2] & ~b[2])
              | (e[3] & e[2] & a[1] & ~b[1])
              | (e[3] & e[2] & e[1] & a[0] & ~b[0]);

  assign altb = (~a[3] & b[3])
              | (e[3] & ~a[2] & b[2])
              | (e[3] & e[2] & ~a[1] & b[1])
              | (e[3] & e[2] & e[1] & ~a[0] & b[0]);

  assign aeqb = &e;

endmodule

// File: rtl/minmax_window_tracker.sv
// Collects WIN_LEN samples, tracks min/max and the over-threshold count, then holds one result.
module minmax_window_tracker
  import minmax_pkg::*;
#(
  parameter int WIN_LEN = 8,
  parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
  input logic                    clk,
  input logic                    rst,
  minmax_window_tracker_if.slave bus
);

  state_t            state, state_nx;
  logic              in_ready_q, out_valid_q;
  logic [DATA_W-1:0] min_q, max_q, thresh_q;
  logic [CNT_W-1:0]  cnt_q, gt_q, cnt_inc;
  logic              acc, last;
  logic              lt_min, gt_max, gt_thr;
  logic              eq_min, eq_max, eq_thr, gt_min, lt_max, lt_thr;
  logic              unused_cmp;

  magComp_gate u_cmp_min (.a(bus.in_data), .b(min_q),    .agtb(gt_min), .aeqb(eq_min), .altb(lt_min));
  magComp_gate u_cmp_max (.a(bus.in_data), .b(max_q),    .agtb(gt_max), .aeqb(eq_max), .altb(lt_max));
  magComp_gate u_cmp_thr (.a(bus.in_data), .b(thresh_q), .agtb(gt_thr), .aeqb(eq_thr), .altb(lt_thr));

  assign unused_cmp = ^{eq_min, eq_max, eq_thr, gt_min, lt_max, lt_thr};

  assign acc     = bus.in_valid & in_ready_q;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign last    = acc & (cnt_inc == CNT_W'(WIN_LEN));

  // start outranks a sample in COLLECT; HOLD ignores start entirely
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (bus.start) state_nx = ST_COLLECT;
      ST_COLLECT: if (!bus.start && last) state_nx = ST_HOLD;
      ST_HOLD:    if (bus.out_ready) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      min_q       <= '0;
      max_q       <= '0;
      thresh_q    <= '0;
      cnt_q       <= '0;
      gt_q        <= '0;
    end else begin
      state       <= state_nx;
      in_ready_q  <= (state_nx == ST_COLLECT);
      out_valid_q <= (state_nx == ST_HOLD);
      if (bus.start && (state != ST_HOLD)) begin
        cnt_q    <= '0;
        gt_q     <= '0;
        thresh_q <= bus.thresh;
      end else if (acc) begin
        cnt_q <= cnt_inc;
        if (~|cnt_q) begin
          min_q <= bus.in_data;
          max_q <= bus.in_data;
        end else begin
          if (lt_min) min_q <= bus.in_data;
          if (gt_max) max_q <= bus.in_data;
        end
        if (gt_thr) gt_q <= gt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.min_val   = min_q;
  assign bus.max_val   = max_q;
  assign bus.gt_count  = gt_q;

endmodule

// File: tb/tb_minmax_window_tracker.sv
// Directed bench for minmax_window_tracker: queue-based window model plus literal checkpoints.
module tb_minmax_window_tracker;
  import minmax_pkg::*;

  localparam int WIN  = 4;
  localparam int CW   = $clog2(WIN + 1);
  localparam int CW1  = $clog2(1 + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   armed = 0;

  always #5 clk = ~clk;

  minmax_window_tracker_if #(.CNT_W(CW))  bus  ();
  minmax_window_tracker_if #(.CNT_W(CW1)) bus1 ();

  minmax_window_tracker #(.WIN_LEN(WIN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  minmax_window_tracker #(.WIN_LEN(1), .CNT_W(CW1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase, the samples accepted in the current window, and derived results
  int   ph;
  int   q[$];
  int   thr, mmin, mmax, mgt;

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; q.delete(); thr = 0; mmin = 0; mmax = 0; mgt = 0;
    end else begin
      case (ph)
        0: if (bus.start) begin ph = 1; q.delete(); thr = int'(bus.thresh); mgt = 0; end
        1: if (bus.start) begin
             q.delete(); thr = int'(bus.thresh); mgt = 0;
           end else if (bus.in_valid) begin
             q.push_back(int'(bus.in_data));
             mmin = q[0]; mmax = q[0]; mgt = 0;
             foreach (q[i]) begin
               if (q[i] < mmin) mmin = q[i];
               if (q[i] > mmax) mmax = q[i];
               if (q[i] > thr) mgt++;
             end
             if (q.size() == WIN) ph = 2;
           end
        default: if (bus.out_ready) ph = 0;
      endcase
    end
    armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready",  int'(bus.in_ready),  int'(ph == 1));
      chk("out_valid", int'(bus.out_valid), int'(ph == 2));
      chk("min_val",   int'(bus.min_val),   mmin);
      chk("max_val",   int'(bus.max_val),   mmax);
      chk("gt_count",  int'(bus.gt_count),  mgt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic open_win(input int t);
    bus.thresh = 4'(t);
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic feed(input int v);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'(v);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input int mn, input int mx, input int g);
    chk({tag, "_ov"},  int'(bus.out_valid), 1);
    chk({tag, "_min"}, int'(bus.min_val), mn);
    chk({tag, "_max"}, int'(bus.max_val), mx);
    chk({tag, "_gt"},  int'(bus.gt_count), g);
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_idle_ov"}, int'(bus.out_valid), 0);
    chk({tag, "_idle_ir"}, int'(bus.in_ready), 0);
  endtask

  initial begin
    int s3[4];
    int v;
    s3 = '{1, 9, 3, 8};
    bus.start = 0; bus.in_valid = 0; bus.in_data = 0; bus.thresh = 0; bus.out_ready = 0;
    bus1.start = 0; bus1.in_valid = 0; bus1.in_data = 0; bus1.thresh = 0; bus1.out_ready = 0;
    step(); step();
    chk("rst_ir", int'(bus.in_ready), 0);
    chk("rst_ov", int'(bus.out_valid), 0);
    chk("rst_min", int'(bus.min_val), 0);
    rst = 1'b0;

    // 1: basic window
    open_win(5);
    chk("t1_ir", int'(bus.in_ready), 1);
    feed(7); feed(2); feed(9); feed(5);
    expect_res("t1", 2, 9, 2);
    drain("t1");

    // 2: boundary values
    open_win(15);
    repeat (4) feed(15);
    expect_res("t2a", 15, 15, 0);
    drain("t2a");
    open_win(0);
    repeat (4) feed(0);
    expect_res("t2b", 0, 0, 0);
    drain("t2b");

    // 3: stalled input and stalled output
    open_win(7);
    v = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = ~i[0];
      bus.in_data  = i[0] ? 4'hF : 4'(s3[v]);
      if (!i[0]) v++;
      step();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) expect_res("t3_hold", 1, 9, 2);
    for (int i = 0; i < 5; i++) step();
    expect_res("t3_end", 1, 9, 2);
    drain("t3");

    // 4: restart mid-window drops the coincident sample
    open_win(0);
    feed(3); feed(8);
    bus.thresh = 4'd1; bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 4'hA;
    step();
    bus.start = 1'b0; bus.in_valid = 1'b0;
    feed(4); feed(4); feed(6);
    chk("t4_not_yet", int'(bus.out_valid), 0);
    feed(2);
    expect_res("t4", 2, 6, 4);
    drain("t4");

    // 5: reset mid-window
    open_win(2);
    feed(9); feed(1); feed(12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_ir", int'(bus.in_ready), 0);
    chk("t5_ov", int'(bus.out_valid), 0);
    chk("t5_min", int'(bus.min_val), 0);
    chk("t5_max", int'(bus.max_val), 0);
    chk("t5_gt", int'(bus.gt_count), 0);
    open_win(3);
    feed(5); feed(1); feed(4); feed(3);
    expect_res("t5b", 1, 5, 2);
    drain("t5b");

    // 6: IDLE ignores in_valid; HOLD ignores start
    for (int i = 0; i < 3; i++) feed(11);
    chk("t6_idle_ir", int'(bus.in_ready), 0);
    chk("t6_idle_ov", int'(bus.out_valid), 0);
    open_win(8);
    feed(10); feed(8); feed(9); feed(3);
    expect_res("t6", 3, 10, 2);
    bus.thresh = 4'd0; bus.start = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0; bus.out_ready = 1'b0;
    chk("t6_hold_start_ir", int'(bus.in_ready), 0);
    chk("t6_hold_start_ov", int'(bus.out_valid), 0);
    step();
    chk("t6_stays_idle", int'(bus.in_ready), 0);

    // single-sample window build
    bus1.thresh = 4'd2; bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    chk("w1_ir", int'(bus1.in_ready), 1);
    bus1.in_valid = 1'b1; bus1.in_data = 4'd6;
    step();
    bus1.in_valid = 1'b0;
    chk("w1_ov", int'(bus1.out_valid), 1);
    chk("w1_min", int'(bus1.min_val), 6);
    chk("w1_max", int'(bus1.max_val), 6);
    chk("w1_gt", int'(bus1.gt_count), 1);
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    chk("w1_idle", int'(bus1.out_valid), 0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
